// File: rtl/color_manager_config_arbiter_if.sv
// Config bus bundle for the Color Manager config arbiter: two requester ports,
// one target port and status flags. slave = arbiter side, master = environment side.
interface color_manager_config_arbiter_if #(
    parameter int unsigned C_ADDR_WIDTH = 4,
    parameter int unsigned C_DATA_WIDTH = 14
);
    logic [C_ADDR_WIDTH-1:0] R0_Addr;
    logic [C_DATA_WIDTH-1:0] R0_Data;
    logic                    R0_Valid;
    logic                    R0_Rdy;
    logic [C_ADDR_WIDTH-1:0] R1_Addr;
    logic [C_DATA_WIDTH-1:0] R1_Data;
    logic                    R1_Valid;
    logic                    R1_Rdy;
    logic [C_ADDR_WIDTH-1:0] T_Addr;
    logic [C_DATA_WIDTH-1:0] T_Data;
    logic                    T_Valid;
    logic                    T_Rdy;
    logic                    Grant_Id;
    logic                    Busy;
    logic [1:0]              Overrun_Valid;
    logic                    Timeout_Valid;
    logic                    Timeout_Id;

    modport slave (
        input  R0_Addr, R0_Data, R0_Valid,
        input  R1_Addr, R1_Data, R1_Valid,
        input  T_Rdy,
        output R0_Rdy, R1_Rdy,
        output T_Addr, T_Data, T_Valid,
        output Grant_Id, Busy, Overrun_Valid, Timeout_Valid, Timeout_Id
    );

    modport master (
        output R0_Addr, R0_Data, R0_Valid,
        output R1_Addr, R1_Data, R1_Valid,
        output T_Rdy,
        input  R0_Rdy, R1_Rdy,
        input  T_Addr, T_Data, T_Valid,
        input  Grant_Id, Busy, Overrun_Valid, Timeout_Valid, Timeout_Id
    );
endinterface

// File: rtl/color_manager_config_arbiter.sv
// Two-requester round-robin arbiter onto the single Color Manager config bus.
// Optional target-stall timeout abort is enabled by defining CM_ARB_TIMEOUT_EN.
module color_manager_config_arbiter #(
    parameter int unsigned C_ADDR_WIDTH      = 4,
    parameter int unsigned C_DATA_WIDTH      = 14,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CNT_WIDTH = 11
) (
    input logic                           Clk,
    input logic                           Rst,
    color_manager_config_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_CNT_WIDTH)) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CNT_WIDTH too small for TIMEOUT_CYCLES");
    end

    logic [0:0]              state, state_nxt;
    logic                    slot0_full, slot0_full_nxt;
    logic                    slot1_full, slot1_full_nxt;
    logic [C_ADDR_WIDTH-1:0] slot0_addr, slot0_addr_nxt;
    logic [C_DATA_WIDTH-1:0] slot0_data, slot0_data_nxt;
    logic [C_ADDR_WIDTH-1:0] slot1_addr, slot1_addr_nxt;
    logic [C_DATA_WIDTH-1:0] slot1_data, slot1_data_nxt;
    logic [C_ADDR_WIDTH-1:0] t_addr, t_addr_nxt;
    logic [C_DATA_WIDTH-1:0] t_data, t_data_nxt;
    logic                    t_valid, t_valid_nxt;
    logic                    grant_id, grant_id_nxt;
    logic                    last_grant, last_grant_nxt;
    logic [1:0]              overrun, overrun_nxt;
    logic                    pick_c;
    logic                    transfer_c;
    logic                    abort_c;
    logic                    done_c;

`ifdef CM_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] TMO_LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
    logic                         tmo_valid, tmo_valid_nxt;
    logic                         tmo_id, tmo_id_nxt;

    assign abort_c = (state == ST_ISSUE) && !bus.T_Rdy && (tmo_cnt == TMO_LAST);
`else
    assign abort_c = 1'b0;
`endif

    // Only one slot full -> that one; both full -> the one not granted last.
    assign pick_c     = (slot0_full && slot1_full) ? ~last_grant : slot1_full;
    assign transfer_c = (state == ST_ISSUE) && bus.T_Rdy;
    assign done_c     = transfer_c || abort_c;

    // Next-state, slot and target-bus logic
    always_comb begin
        state_nxt      = state;
        slot0_full_nxt = slot0_full;
        slot1_full_nxt = slot1_full;
        slot0_addr_nxt = slot0_addr;
        slot0_data_nxt = slot0_data;
        slot1_addr_nxt = slot1_addr;
        slot1_data_nxt = slot1_data;
        t_addr_nxt     = t_addr;
        t_data_nxt     = t_data;
        t_valid_nxt    = t_valid;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        overrun_nxt    = 2'b00;
`ifdef CM_ARB_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
        tmo_valid_nxt  = 1'b0;
        tmo_id_nxt     = tmo_id;
`endif

        case (state)
            ST_IDLE: begin
                if (slot0_full || slot1_full) begin
                    state_nxt      = ST_ISSUE;
                    t_valid_nxt    = 1'b1;
                    grant_id_nxt   = pick_c;
                    last_grant_nxt = pick_c;
                    t_addr_nxt     = pick_c ? slot1_addr : slot0_addr;
                    t_data_nxt     = pick_c ? slot1_data : slot0_data;
`ifdef CM_ARB_TIMEOUT_EN
                    tmo_cnt_nxt    = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (done_c) begin
                    state_nxt   = ST_IDLE;
                    t_valid_nxt = 1'b0;
                end
`ifdef CM_ARB_TIMEOUT_EN
                if (abort_c) begin
                    tmo_valid_nxt = 1'b1;
                    tmo_id_nxt    = grant_id;
                end else if (!bus.T_Rdy) begin
                    tmo_cnt_nxt = tmo_cnt + TIMEOUT_CNT_WIDTH'(1);
                end
`endif
            end
            default: begin
                state_nxt   = ST_IDLE;
                t_valid_nxt = 1'b0;
            end
        endcase

        // A slot being cleared this edge still counts as full for new requests.
        if (done_c && !grant_id) slot0_full_nxt = 1'b0;
        if (done_c &&  grant_id) slot1_full_nxt = 1'b0;

        if (bus.R0_Valid) begin
            if (slot0_full) begin
                overrun_nxt[0] = 1'b1;
            end else begin
                slot0_full_nxt = 1'b1;
                slot0_addr_nxt = bus.R0_Addr;
                slot0_data_nxt = bus.R0_Data;
            end
        end
        if (bus.R1_Valid) begin
            if (slot1_full) begin
                overrun_nxt[1] = 1'b1;
            end else begin
                slot1_full_nxt = 1'b1;
                slot1_addr_nxt = bus.R1_Addr;
                slot1_data_nxt = bus.R1_Data;
            end
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            slot0_full <= 1'b0;
            slot1_full <= 1'b0;
            slot0_addr <= '0;
            slot0_data <= '0;
            slot1_addr <= '0;
            slot1_data <= '0;
            t_addr     <= '0;
            t_data     <= '0;
            t_valid    <= 1'b0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            overrun    <= 2'b00;
        end else begin
            state      <= state_nxt;
            slot0_full <= slot0_full_nxt;
            slot1_full <= slot1_full_nxt;
            slot0_addr <= slot0_addr_nxt;
            slot0_data <= slot0_data_nxt;
            slot1_addr <= slot1_addr_nxt;
            slot1_data <= slot1_data_nxt;
            t_addr     <= t_addr_nxt;
            t_data     <= t_data_nxt;
            t_valid    <= t_valid_nxt;
            grant_id   <= grant_id_nxt;
            last_grant <= last_grant_nxt;
            overrun    <= overrun_nxt;
        end
    end

`ifdef CM_ARB_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            tmo_cnt   <= '0;
            tmo_valid <= 1'b0;
            tmo_id    <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_cnt_nxt;
            tmo_valid <= tmo_valid_nxt;
            tmo_id    <= tmo_id_nxt;
        end
    end

    assign bus.Timeout_Valid = tmo_valid;
    assign bus.Timeout_Id    = tmo_id;
`else
    assign bus.Timeout_Valid = 1'b0;
    assign bus.Timeout_Id    = 1'b0;
`endif

    assign bus.R0_Rdy        = ~slot0_full;
    assign bus.R1_Rdy        = ~slot1_full;
    assign bus.T_Addr        = t_addr;
    assign bus.T_Data        = t_data;
    assign bus.T_Valid       = t_valid;
    assign bus.Grant_Id      = grant_id;
    assign bus.Busy          = (state == ST_ISSUE);
    assign bus.Overrun_Valid = overrun;

endmodule

// File: tb/tb_color_manager_config_arbiter.sv
// Scoreboard bench for color_manager_config_arbiter: expected target transfers
// are queued when requests are driven and checked when the target accepts.
module tb_color_manager_config_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 14;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic rr_last;
    logic [AW+DW:0] sb[$];

    color_manager_config_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    color_manager_config_arbiter #(
        .C_ADDR_WIDTH      (AW),
        .C_DATA_WIDTH      (DW),
        .TIMEOUT_CYCLES    (8),
        .TIMEOUT_CNT_WIDTH (4)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back({id, a, d});
    endtask

    task automatic pulse(input logic id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin
            bus.R1_Addr = a; bus.R1_Data = d; bus.R1_Valid = 1'b1;
        end else begin
            bus.R0_Addr = a; bus.R0_Data = d; bus.R0_Valid = 1'b1;
        end
        tick();
        bus.R0_Valid = 1'b0;
        bus.R1_Valid = 1'b0;
    endtask

    // Both requesters on the same edge into an idle, empty arbiter.
    task automatic pulse_pair(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.R0_Addr = a0; bus.R0_Data = d0; bus.R0_Valid = 1'b1;
        bus.R1_Addr = a1; bus.R1_Data = d1; bus.R1_Valid = 1'b1;
        if (rr_last) begin
            push_exp(1'b0, a0, d0); push_exp(1'b1, a1, d1); rr_last = 1'b1;
        end else begin
            push_exp(1'b1, a1, d1); push_exp(1'b0, a0, d0); rr_last = 1'b0;
        end
        tick();
        bus.R0_Valid = 1'b0;
        bus.R1_Valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !bus.T_Valid && bus.R0_Rdy && bus.R1_Rdy) break;
            tick();
        end
        check_eq("drain_queue", 32'(sb.size()), 32'd0);
        check_eq("drain_tvalid", 32'(bus.T_Valid), 32'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        rr_last = 1'b1;
        sb.delete();
    endtask

    // Monitor: a transfer happens at the coming edge whenever T_Valid and T_Rdy are both high.
    always @(negedge clk) begin
        if (rst && bus.T_Valid && bus.T_Rdy) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                logic [AW+DW:0] e;
                e = sb.pop_front();
                check_eq("xfer_id",   32'(bus.Grant_Id), 32'(e[AW+DW]));
                check_eq("xfer_addr", 32'(bus.T_Addr),   32'(e[AW+DW-1:DW]));
                check_eq("xfer_data", 32'(bus.T_Data),   32'(e[DW-1:0]));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rr_last = 1'b1;
        bus.R0_Addr = '0; bus.R0_Data = '0; bus.R0_Valid = 1'b0;
        bus.R1_Addr = '0; bus.R1_Data = '0; bus.R1_Valid = 1'b0;
        bus.T_Rdy = 1'b0;

        // Reset state
        reset_dut();
        check_eq("rst_tvalid", 32'(bus.T_Valid), 32'd0);
        check_eq("rst_taddr", 32'(bus.T_Addr), 32'd0);
        check_eq("rst_tdata", 32'(bus.T_Data), 32'd0);
        check_eq("rst_grant", 32'(bus.Grant_Id), 32'd0);
        check_eq("rst_busy", 32'(bus.Busy), 32'd0);
        check_eq("rst_rdy", 32'({bus.R1_Rdy, bus.R0_Rdy}), 32'd3);
        check_eq("rst_overrun", 32'(bus.Overrun_Valid), 32'd0);
        check_eq("rst_timeout", 32'({bus.Timeout_Valid, bus.Timeout_Id}), 32'd0);

        // Single request latency with target ready
        bus.T_Rdy = 1'b1;
        push_exp(1'b0, 4'h2, 14'h0005);
        rr_last = 1'b0;
        pulse(1'b0, 4'h2, 14'h0005);
        check_eq("lat_r0rdy_low", 32'(bus.R0_Rdy), 32'd0);
        check_eq("lat_tvalid_n", 32'(bus.T_Valid), 32'd0);
        tick();
        check_eq("lat_tvalid_n1", 32'(bus.T_Valid), 32'd1);
        check_eq("lat_taddr", 32'(bus.T_Addr), 32'h2);
        check_eq("lat_tdata", 32'(bus.T_Data), 32'h5);
        check_eq("lat_grant", 32'(bus.Grant_Id), 32'd0);
        tick();
        check_eq("lat_tvalid_n2", 32'(bus.T_Valid), 32'd0);
        check_eq("lat_r0rdy_back", 32'(bus.R0_Rdy), 32'd1);
        wait_drain();

        // Round-robin: pair from reset, R0 alone, then the pair again
        reset_dut();
        bus.T_Rdy = 1'b1;
        pulse_pair(4'h1, 14'h0003, 4'h5, 14'h0ABC);
        wait_drain();
        push_exp(1'b0, 4'h8, 14'h0042);
        rr_last = 1'b0;
        pulse(1'b0, 4'h8, 14'h0042);
        wait_drain();
        pulse_pair(4'h1, 14'h0003, 4'h5, 14'h0ABC);
        wait_drain();

        // Target stall: issue must hold steady
        bus.T_Rdy = 1'b0;
        push_exp(1'b0, 4'h7, 14'h1234);
        rr_last = 1'b0;
        pulse(1'b0, 4'h7, 14'h1234);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_tvalid", 32'(bus.T_Valid), 32'd1);
            check_eq("stall_taddr", 32'(bus.T_Addr), 32'h7);
            check_eq("stall_tdata", 32'(bus.T_Data), 32'h1234);
            check_eq("stall_busy", 32'(bus.Busy), 32'd1);
            tick();
        end
        bus.T_Rdy = 1'b1;
        tick();
        check_eq("stall_busy_fall", 32'(bus.Busy), 32'd0);
        check_eq("stall_tvalid_fall", 32'(bus.T_Valid), 32'd0);
        wait_drain();

        // Overrun on a full R1 slot; original data still delivered
        bus.T_Rdy = 1'b0;
        push_exp(1'b1, 4'h3, 14'h0AAA);
        rr_last = 1'b1;
        pulse(1'b1, 4'h3, 14'h0AAA);
        check_eq("ovr_none_yet", 32'(bus.Overrun_Valid), 32'd0);
        pulse(1'b1, 4'h3, 14'h0111);
        check_eq("ovr_pulse", 32'(bus.Overrun_Valid), 32'h2);
        tick();
        check_eq("ovr_cleared", 32'(bus.Overrun_Valid), 32'd0);
        check_eq("ovr_data_kept", 32'(bus.T_Data), 32'h0AAA);
        bus.T_Rdy = 1'b1;
        wait_drain();

`ifdef CM_ARB_TIMEOUT_EN
        // Timeout abort after 8 stalled issue cycles; next request then issues
        bus.T_Rdy = 1'b0;
        pulse(1'b0, 4'h9, 14'h0BAD);
        check_eq("tmo_tvalid_pre", 32'(bus.T_Valid), 32'd0);
        push_exp(1'b1, 4'h6, 14'h0222);
        rr_last = 1'b1;
        pulse(1'b1, 4'h6, 14'h0222);
        check_eq("tmo_issue_hi", 32'(bus.T_Valid), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_eq("tmo_hold_hi", 32'(bus.T_Valid), 32'd1);
            check_eq("tmo_no_pulse", 32'(bus.Timeout_Valid), 32'd0);
        end
        tick();
        check_eq("tmo_tvalid_drop", 32'(bus.T_Valid), 32'd0);
        check_eq("tmo_valid", 32'(bus.Timeout_Valid), 32'd1);
        check_eq("tmo_id", 32'(bus.Timeout_Id), 32'd0);
        check_eq("tmo_r0rdy", 32'(bus.R0_Rdy), 32'd1);
        tick();
        check_eq("tmo_valid_end", 32'(bus.Timeout_Valid), 32'd0);
        check_eq("tmo_next_issue", 32'(bus.T_Valid), 32'd1);
        check_eq("tmo_next_grant", 32'(bus.Grant_Id), 32'd1);
        bus.T_Rdy = 1'b1;
        wait_drain();
`endif

        // Reset during issue discards everything silently
        bus.T_Rdy = 1'b0;
        bus.R0_Addr = 4'hA; bus.R0_Data = 14'h0010; bus.R0_Valid = 1'b1;
        bus.R1_Addr = 4'hB; bus.R1_Data = 14'h0020; bus.R1_Valid = 1'b1;
        tick();
        bus.R0_Valid = 1'b0;
        bus.R1_Valid = 1'b0;
        tick();
        check_eq("mid_busy", 32'(bus.Busy), 32'd1);
        rst = 1'b0;
        tick();
        check_eq("mid_tvalid", 32'(bus.T_Valid), 32'd0);
        check_eq("mid_rdy", 32'({bus.R1_Rdy, bus.R0_Rdy}), 32'd3);
        check_eq("mid_overrun", 32'(bus.Overrun_Valid), 32'd0);
        check_eq("mid_timeout", 32'(bus.Timeout_Valid), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        check_eq("mid_post_tvalid", 32'(bus.T_Valid), 32'd0);
        check_eq("mid_post_busy", 32'(bus.Busy), 32'd0);
        check_eq("final_queue", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
